// File: rtl/dmem_bus_if_if.sv
// Data-memory bus bundle: registered cyc/stb request side from the master,
// read data and acknowledge back from the slave.
interface dmem_bus_if_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output cyc, stb, we, addr, sel, wdata,
        input  rdata, ack
    );

    modport slave (
        input  cyc, stb, we, addr, sel, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/dmem_bus_if.sv
// MEM-stage to data bus bridge: one registered cyc/stb transaction per request,
// stall request while outstanding, watchdog abort, and load data held across stalls.
module dmem_bus_if #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq,
    output logic        timeout_o,
    dmem_bus_if_if.master bus
);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rd_buf;

    logic mem_held;
    logic ack_hit;
    logic wd_fire;
    logic unused_stall;

    assign mem_held     = stall[4];
    assign unused_stall = ^{stall[5], stall[3:0]};

    // flush outranks both a real ack and the watchdog
    assign ack_hit = (state == BUSY) && bus.ack && !flush;
    assign wd_fire = (state == BUSY) && !bus.ack && !flush
                   && (cnt == CNT_W'(TIMEOUT - 1));

    assign timeout_o = wd_fire;

    always_comb begin
        stallreq   = 1'b0;
        cpu_data_o = 32'h0;
        case (state)
            IDLE: stallreq = cpu_ce_i && !flush && rst;
            BUSY: begin
                if (ack_hit)
                    cpu_data_o = bus.we ? 32'h0 : bus.rdata;
                else
                    stallreq = !flush && !wd_fire;
            end
            HOLD: if (!flush) cpu_data_o = rd_buf;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_buf    <= 32'h0;
            bus.cyc   <= 1'b0;
            bus.stb   <= 1'b0;
            bus.we    <= 1'b0;
            bus.addr  <= 32'h0;
            bus.sel   <= 4'h0;
            bus.wdata <= 32'h0;
        end else if (flush) begin
            state   <= IDLE;
            cnt     <= '0;
            bus.cyc <= 1'b0;
            bus.stb <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_ce_i) begin
                        bus.cyc   <= 1'b1;
                        bus.stb   <= 1'b1;
                        bus.we    <= cpu_we_i;
                        bus.addr  <= cpu_addr_i;
                        bus.sel   <= cpu_sel_i;
                        bus.wdata <= cpu_data_i;
                        cnt       <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (ack_hit) begin
                        bus.cyc <= 1'b0;
                        bus.stb <= 1'b0;
                        // stores return zero so HOLD never exposes slave junk
                        rd_buf  <= bus.we ? 32'h0 : bus.rdata;
                        cnt     <= '0;
                        state   <= mem_held ? HOLD : IDLE;
                    end else if (wd_fire) begin
                        bus.cyc <= 1'b0;
                        bus.stb <= 1'b0;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: if (!mem_held) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
